lsu_dtcm_master: RTL

- LSU-side initiator for the DTCM command/response interface. It is the requester that drives the DTCM controller.
- Accepts one load/store request at a time from the EXU/AGU.
- Generates the word address, byte write mask and replicated write data, then drives the cmd handshake and waits for the rsp handshake.
- For loads, aligns and sign/zero-extends the read data; returns a writeback/completion handshake to the EXU.

---
 rtl/lsu_dtcm_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_dtcm_master.sv
// rtl/lsu_dtcm_master.sv - LSU-side DTCM cmd/rsp initiator with load alignment/extension
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_dtcm_master #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 14,
  parameter int RAM_DW = 32,
  parameter int RAM_MW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [RAM_DW-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              lsu2dtcm_cmd_valid,
  input  logic              lsu2dtcm_cmd_ready,
  output logic              lsu2dtcm_cmd_read,
  output logic [RAM_AW-1:0] lsu2dtcm_cmd_addr,
  output logic [RAM_MW-1:0] lsu2dtcm_cmd_wmask,
  output logic [RAM_DW-1:0] lsu2dtcm_cmd_wdata,
  input  logic              lsu2dtcm_rsp_valid,
  output logic              lsu2dtcm_rsp_ready,
  input  logic [RAM_DW-1:0] lsu2dtcm_rsp_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [RAM_DW-1:0] wb_data,
  output logic              wb_err
);

  typedef enum logic [1:0] {IDLE, CMD, RSP, WB} state_t;

  state_t state_q, state_d;

  logic              read_q, unsigned_q;
  logic [1:0]        size_q, lo_q;
  logic [RAM_AW-1:0] cmd_addr_q;
  logic [RAM_MW-1:0] wmask_q;
  logic [RAM_DW-1:0] wdata_q;
  logic              wb_we_q, wb_err_q;
  logic [4:0]        wb_rd_q;
  logic [RAM_DW-1:0] wb_data_q;

  logic              accept, rsp_take, misalign;
  logic [RAM_MW-1:0] req_mask;
  logic [RAM_DW-1:0] req_wdata_rep;
  logic [RAM_DW-1:0] byte_sh, half_sh, load_data;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:RAM_AW+2];

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((req_size == 2'b01) & req_addr[0]) | (req_size[1] & (|req_addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    req_mask      = '1;
    req_wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        req_mask      = {{(RAM_MW-1){1'b0}}, 1'b1} << req_addr[1:0];
        req_wdata_rep = {(RAM_DW/8){req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask      = {{(RAM_MW-2){1'b0}}, 2'b11} << {req_addr[1], 1'b0};
        req_wdata_rep = {(RAM_DW/16){req_wdata[15:0]}};
      end
      default: begin
        req_mask      = '1;
        req_wdata_rep = req_wdata;
      end
    endcase
  end

  // Lane select and extension use the request attributes captured at accept.
  assign byte_sh = lsu2dtcm_rsp_rdata >> {lo_q, 3'b000};
  assign half_sh = lsu2dtcm_rsp_rdata >> {lo_q[1], 4'b0000};

  always_comb begin
    load_data = lsu2dtcm_rsp_rdata;
    case (size_q)
      2'b00:   load_data = {{(RAM_DW-8){byte_sh[7] & ~unsigned_q}}, byte_sh[7:0]};
      2'b01:   load_data = {{(RAM_DW-16){half_sh[15] & ~unsigned_q}}, half_sh[15:0]};
      default: load_data = lsu2dtcm_rsp_rdata;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    req_ready          = 1'b0;
    lsu2dtcm_cmd_valid = 1'b0;
    lsu2dtcm_rsp_ready = 1'b0;
    wb_valid           = 1'b0;
    accept             = 1'b0;
    rsp_take           = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = misalign ? WB : CMD;
        end
      end
      CMD: begin
        lsu2dtcm_cmd_valid = 1'b1;
        lsu2dtcm_rsp_ready = 1'b1;
        if (lsu2dtcm_cmd_ready) begin
          if (lsu2dtcm_rsp_valid) begin
            rsp_take = 1'b1;
            state_d  = WB;
          end else begin
            state_d  = RSP;
          end
        end
      end
      RSP: begin
        lsu2dtcm_rsp_ready = 1'b1;
        if (lsu2dtcm_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = WB;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      cmd_addr_q <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        read_q     <= req_read;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        lo_q       <= req_addr[1:0];
        cmd_addr_q <= req_addr[RAM_AW+1:2];
        wmask_q    <= req_read ? '0 : req_mask;
        wdata_q    <= req_wdata_rep;
        wb_we_q    <= req_read & ~misalign;
        wb_err_q   <= misalign;
        wb_rd_q    <= req_rd;
        wb_data_q  <= '0;
      end
      // Store responses carry no data; wb_data stays 0 from accept.
      if (rsp_take && read_q) wb_data_q <= load_data;
    end
  end

  assign lsu2dtcm_cmd_read  = read_q;
  assign lsu2dtcm_cmd_addr  = cmd_addr_q;
  assign lsu2dtcm_cmd_wmask = wmask_q;
  assign lsu2dtcm_cmd_wdata = wdata_q;
  assign wb_we              = wb_we_q;
  assign wb_rd              = wb_rd_q;
  assign wb_data            = wb_data_q;
  assign wb_err             = wb_err_q;

endmodule
